cipher_loader: RTL and testbench

CIPHER_LOADER -- requirements
Module: cipher_loader

---
 rtl/cipher_loader.sv | 170 +++++++++++++++++
 tb/tb_cipher_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_loader.sv
// rtl/cipher_loader.sv - assembles a byte stream into a cipher frame and commits it atomically
//
// Purpose: collects NUM_BYTES received bytes into a staging register and copies
// the complete frame onto cipher in a single commit cycle. Partial frames can be
// abandoned by clear or by an inter-byte gap timeout. A registered display slice
// of the committed cipher is selected by sel.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   rx_data    received byte
//   rx_valid   rx_data valid, held by the source until rx_ack
//   rx_ack     byte accepted this cycle (combinational)
//   clear      abandon the frame in progress
//   sel        display slice index
//   cipher     last committed frame
//   disp_data  registered slice sel of cipher (0 for an out-of-range sel)
//   byte_count bytes accepted in the current frame
//   busy       frame loading or committing
//   load_done  one-cycle pulse, coincident with the cipher update
//   timeout    sticky flag: last frame abandoned on an inter-byte gap
//   frame_cnt  committed frame count, wraps 255 -> 0
module cipher_loader #(
    parameter int                      NUM_BYTES     = 16,
    parameter logic [NUM_BYTES*8-1:0]  RESET_VALUE   = 128'ha13a3ab3071897088f3233a58d6238bb,
    parameter int                      CLK_FREQUENCY = 100_000_000,
    parameter int                      TIMEOUT_US    = 10_000,
    parameter int                      DISP_WIDTH    = 16,
    localparam int                     W             = NUM_BYTES * 8,
    localparam int                     NSLICE        = W / DISP_WIDTH,
    localparam int                     SEL_W         = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int                     BC_W          = $clog2(NUM_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ack,
    input  logic                  clear,
    input  logic [SEL_W-1:0]      sel,
    output logic [W-1:0]          cipher,
    output logic [DISP_WIDTH-1:0] disp_data,
    output logic [BC_W-1:0]       byte_count,
    output logic                  busy,
    output logic                  load_done,
    output logic                  timeout,
    output logic [7:0]            frame_cnt
);

    localparam int TIMEOUT_CYCLES = CLK_FREQUENCY / 1_000_000 * TIMEOUT_US;
    localparam int GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [W-1:0]        staging;
    logic [GAP_W-1:0]    gap_cnt;
    logic                gap_hit;
    logic                last_byte;
    logic [DISP_WIDTH-1:0] disp_next;

    // The gap counter is compared against its final value; the abandon happens
    // on the cycle the counter already sits at TIMEOUT_CYCLES-1 with no byte.
    assign gap_hit   = (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));
    assign last_byte = (byte_count == BC_W'(NUM_BYTES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear outranks both a new byte and the gap timeout
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_ack) begin
                    state_next = S_LOADING;
                end
            end
            S_LOADING: begin
                if (clear) begin
                    state_next = S_IDLE;
                end else if (rx_ack) begin
                    if (last_byte) begin
                        state_next = S_COMMIT;
                    end
                end else if (gap_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; bytes stall for the single commit cycle
    always_comb begin
        rx_ack = rx_valid & ~clear & (state != S_COMMIT) & ~rst;
        busy   = (state != S_IDLE);
    end

    // Slice mux for the display register
    always_comb begin
        disp_next = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (sel == SEL_W'(i)) begin
                disp_next = cipher[i*DISP_WIDTH +: DISP_WIDTH];
            end
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cipher     <= RESET_VALUE;
            staging    <= '0;
            byte_count <= '0;
            gap_cnt    <= '0;
            load_done  <= 1'b0;
            timeout    <= 1'b0;
            frame_cnt  <= 8'd0;
            disp_data  <= '0;
        end else begin
            disp_data <= disp_next;
            load_done <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                cipher     <= staging;
                frame_cnt  <= frame_cnt + 8'd1;
                byte_count <= '0;
                gap_cnt    <= '0;
            end else if ((state == S_LOADING) && clear) begin
                staging    <= '0;
                byte_count <= '0;
                gap_cnt    <= '0;
            end else if (rx_ack) begin
                // First byte of a frame ends up in the MSB after NUM_BYTES shifts
                staging    <= {staging[W-9:0], rx_data};
                byte_count <= byte_count + BC_W'(1);
                gap_cnt    <= '0;
                if (state == S_IDLE) begin
                    timeout <= 1'b0;
                end
            end else if (state == S_LOADING) begin
                if (gap_hit) begin
                    staging    <= '0;
                    byte_count <= '0;
                    gap_cnt    <= '0;
                    timeout    <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cipher_loader.sv
// tb/tb_cipher_loader.sv - self-checking bench for cipher_loader with a frame-level reference model
module tb_cipher_loader;

    localparam int          NB  = 4;
    localparam logic [31:0] RV  = 32'hA13A3AB3;
    localparam int          DW  = 8;
    localparam int          CF  = 1_000_000;
    localparam int          TU  = 20;
    localparam int          TC  = CF / 1_000_000 * TU;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        clear;
    logic [1:0]  sel;
    logic [31:0] cipher;
    logic [7:0]  disp_data;
    logic [2:0]  byte_count;
    logic        busy;
    logic        load_done;
    logic        timeout;
    logic [7:0]  frame_cnt;

    cipher_loader #(
        .NUM_BYTES     (NB),
        .RESET_VALUE   (RV),
        .CLK_FREQUENCY (CF),
        .TIMEOUT_US    (TU),
        .DISP_WIDTH    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .clear      (clear),
        .sel        (sel),
        .cipher     (cipher),
        .disp_data  (disp_data),
        .byte_count (byte_count),
        .busy       (busy),
        .load_done  (load_done),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the frame in progress is a byte queue; a full queue
    // waits one cycle (m_commit) and is then folded into the cipher word.
    logic [31:0] m_cipher;
    logic [7:0]  m_bytes[$];
    bit          m_commit = 0;
    int          m_gap;
    bit          m_timeout;
    int          m_frames;
    bit          m_load_done;
    logic [7:0]  m_disp;
    bit          last_ack;

    function automatic bit model_ack(input bit r, input bit v, input bit c);
        return !r && v && !c && !m_commit;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c, input logic [1:0] s);
        logic [31:0] acc;
        bit ack;
        if (r) begin
            m_cipher = RV;
            m_bytes.delete();
            m_commit = 0;
            m_gap = 0;
            m_timeout = 0;
            m_frames = 0;
            m_load_done = 0;
            m_disp = 8'h00;
            return;
        end
        ack = model_ack(r, v, c);
        m_disp = 8'((m_cipher >> (int'(s) * 8)) & 32'hFF);
        if (m_commit) begin
            acc = 32'h0;
            foreach (m_bytes[i]) acc = (acc << 8) | 32'(m_bytes[i]);
            m_cipher = acc;
            m_bytes.delete();
            m_frames = (m_frames + 1) % 256;
            m_load_done = 1;
            m_commit = 0;
            m_gap = 0;
        end else begin
            m_load_done = 0;
            if (m_bytes.size() > 0) begin
                if (c) begin
                    m_bytes.delete();
                    m_gap = 0;
                end else if (ack) begin
                    m_bytes.push_back(d);
                    m_gap = 0;
                    if (m_bytes.size() == NB) m_commit = 1;
                end else if (m_gap == TC - 1) begin
                    m_bytes.delete();
                    m_gap = 0;
                    m_timeout = 1;
                end else begin
                    m_gap++;
                end
            end else if (ack) begin
                m_bytes.push_back(d);
                m_gap = 0;
                m_timeout = 0;
            end
        end
    endtask

    // One clock: drive inputs after the falling edge, check the combinational
    // handshake, advance model on the rising edge, check registers at the next fall.
    task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit c, input logic [1:0] s);
        rst = r; rx_valid = v; rx_data = d; clear = c; sel = s;
        #1;
        last_ack = rx_ack;
        chk("rx_ack", 64'(rx_ack), 64'(model_ack(r, v, c)));
        @(posedge clk);
        model_step(r, v, d, c, s);
        @(negedge clk);
        chk("cipher",     64'(cipher),     64'(m_cipher));
        chk("disp_data",  64'(disp_data),  64'(m_disp));
        chk("byte_count", 64'(byte_count), 64'(m_bytes.size()));
        chk("busy",       64'(busy),       64'((m_bytes.size() > 0) || m_commit));
        chk("load_done",  64'(load_done),  64'(m_load_done));
        chk("timeout",    64'(timeout),    64'(m_timeout));
        chk("frame_cnt",  64'(frame_cnt),  64'(m_frames));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 2'd3);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick(0, 1, b, 0, 2'd3);
            done = last_ack;
        end
        if (!done) chk("send_ack_bound", 64'(0), 64'(1));
        idle(gap);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear = 1'b0; sel = 2'd3;
        @(negedge clk);

        // Reset state and display of the top slice
        tick(1, 0, 8'h00, 0, 2'd3);
        tick(1, 1, 8'h5A, 1, 2'd3);
        tick(0, 0, 8'h00, 0, 2'd3);
        chk("rst_cipher", 64'(cipher), 64'h A13A3AB3);
        chk("rst_disp",   64'(disp_data), 64'h A1);
        chk("rst_busy",   64'(busy), 64'(0));
        chk("rst_frames", 64'(frame_cnt), 64'(0));

        // Full frame with 2-cycle gaps
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        send_byte(8'h44, 0);
        chk("commit_wait_cipher", 64'(cipher), 64'h A13A3AB3);
        idle(1);
        chk("frame_cipher", 64'(cipher), 64'h 11223344);
        chk("frame_done",   64'(load_done), 64'(1));
        chk("frame_cnt1",   64'(frame_cnt), 64'(1));
        chk("frame_bc",     64'(byte_count), 64'(0));
        idle(1);
        chk("done_pulse",   64'(load_done), 64'(0));

        // Gap timeout lands exactly TC cycles after the last ack
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        idle(TC - 1);
        chk("to_early", 64'(timeout), 64'(0));
        idle(1);
        chk("to_set", 64'(timeout), 64'(1));
        idle(5);
        chk("to_cipher", 64'(cipher), 64'h 11223344);
        send_byte(8'h88, 0);
        chk("to_clear", 64'(timeout), 64'(0));
        tick(0, 0, 8'h00, 1, 2'd0);
        chk("clear_bc", 64'(byte_count), 64'(0));

        // Continuous valid: the 5th byte stalls through the commit cycle
        tick(0, 1, 8'h01, 0, 2'd1);
        tick(0, 1, 8'h02, 0, 2'd1);
        tick(0, 1, 8'h03, 0, 2'd1);
        tick(0, 1, 8'h04, 0, 2'd1);
        tick(0, 1, 8'h77, 0, 2'd1);
        chk("stall_ack", 64'(last_ack), 64'(0));
        tick(0, 1, 8'h77, 0, 2'd1);
        chk("stall_accept", 64'(last_ack), 64'(1));
        chk("stall_bc", 64'(byte_count), 64'(1));
        chk("stall_cipher", 64'(cipher), 64'h 01020304);
        tick(0, 0, 8'h00, 1, 2'd1);

        // clear beats a valid byte; reset mid-frame restores RESET_VALUE
        send_byte(8'hA0, 0);
        send_byte(8'hA1, 0);
        tick(0, 1, 8'hA2, 1, 2'd2);
        chk("clr_ack", 64'(last_ack), 64'(0));
        chk("clr_bc", 64'(byte_count), 64'(0));
        chk("clr_to", 64'(timeout), 64'(0));
        send_byte(8'hB0, 0);
        send_byte(8'hB1, 0);
        send_byte(8'hB2, 0);
        tick(1, 1, 8'hB3, 0, 2'd2);
        chk("rst_mid_cipher", 64'(cipher), 64'h A13A3AB3);
        chk("rst_mid_bc", 64'(byte_count), 64'(0));

        // 256 back-to-back frames wrap the frame counter
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < NB; i++) tick(0, 1, 8'($urandom), 0, 2'($urandom));
            tick(0, 0, 8'h00, 0, 2'($urandom));
            if (f == 254) chk("frames_255", 64'(frame_cnt), 64'(255));
        end
        chk("frames_wrap", 64'(frame_cnt), 64'(0));

        // Randomised traffic with bursty, sparse and silent phases
        for (int seg = 0; seg < 60; seg++) begin
            int p;
            case ($urandom_range(0, 2))
                0:       p = 90;
                1:       p = 40;
                default: p = 2;
            endcase
            for (int i = 0; i < 50; i++) begin
                tick(($urandom_range(0, 999) < 2),
                     ($urandom_range(0, 99) < p),
                     8'($urandom),
                     ($urandom_range(0, 99) < 3),
                     2'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
